// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: FSM states, width codes, requester selects.
// Imported by the arbiter, its alignment checker and the bench.
package mem_arb_pkg;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC_I  = 3'd1,
    ST_ACC_D  = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle of mem_arbiter.
// slave = the arbiter, master = CPU stages plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [1:0]        d_width;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] m_addr;
  logic              m_i_en;
  logic              m_d_en;
  logic              m_d_write_n;
  logic [1:0]        m_width;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_irdata;
  logic [DATA_W-1:0] m_drdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_addr, d_we, d_width, d_wdata,
    input  m_irdata, m_drdata,
    output i_gnt, i_valid, i_rdata, i_err,
    output d_gnt, d_valid, d_rdata, d_err,
    output m_addr, m_i_en, m_d_en,
    output m_d_write_n, m_width, m_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_addr, d_we, d_width, d_wdata,
    output m_irdata, m_drdata,
    input  i_gnt, i_valid, i_rdata, i_err,
    input  d_gnt, d_valid, d_rdata, d_err,
    input  m_addr, m_i_en, m_d_en,
    input  m_d_write_n, m_width, m_wdata
  );

endinterface

// File: rtl/mem_arb_align_chk.sv
// Alignment / width legality check for the requester being granted.
// Purely combinational.
module mem_arb_align_chk
  import mem_arb_pkg::*;
(
  input  logic [1:0] addr_i,
  input  logic [1:0] width_i,
  input  logic       is_fetch_i,
  output logic       err_o
);

  // Fetches are always words; data checks depend on width code
  always_comb begin
    err_o = 1'b0;
    if (is_fetch_i) begin
      err_o = |addr_i;
    end else begin
      unique case (width_i)
        W_BYTE:  err_o = 1'b0;
        W_HALF:  err_o = addr_i[0];
        W_WORD:  err_o = |addr_i;
        default: err_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data requesters.
// Define MEM_ARB_RR_EN for round-robin, else data has priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_e state_q, state_d;

  logic              sel;
  logic              any_gnt;
  logic              gnt_i;
  logic              gnt_d;
  logic              err;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] i_rd;
  logic [DATA_W-1:0] d_rd;

  logic              we_q;
  logic              i_valid_q;
  logic              d_valid_q;
  logic              i_err_q;
  logic              d_err_q;
  logic              m_i_en_q;
  logic              m_d_en_q;
  logic              m_d_write_n_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [1:0]        m_width_q;
  logic [DATA_W-1:0] m_wdata_q;

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Contested requests go to whoever was not served last
  always_comb begin
    sel = SEL_I;
    if (bus.d_req && bus.i_req) begin
      sel = (last_q == SEL_I) ? SEL_D : SEL_I;
    end else if (bus.d_req) begin
      sel = SEL_D;
    end
  end

  // Track last served requester, error grants included
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= SEL_I;
    end else if (any_gnt) begin
      last_q <= sel;
    end
  end
`else
  // Fixed priority: data beats instruction
  always_comb begin
    sel = bus.d_req ? SEL_D : SEL_I;
  end
`endif

  assign any_gnt  = !reset && (state_q == ST_IDLE)
                    && (bus.i_req || bus.d_req);
  assign gnt_i    = any_gnt && (sel == SEL_I);
  assign gnt_d    = any_gnt && (sel == SEL_D);
  assign gnt_addr = (sel == SEL_D) ? bus.d_addr : bus.i_addr;

  mem_arb_align_chk u_align (
    .addr_i     (gnt_addr[1:0]),
    .width_i    (bus.d_width),
    .is_fetch_i (sel == SEL_I),
    .err_o      (err)
  );

  // Error grants skip the memory access entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_i) begin
          state_d = err ? ST_RESP_I : ST_ACC_I;
        end else if (gnt_d) begin
          state_d = err ? ST_RESP_D : ST_ACC_D;
        end
      end
      ST_ACC_I: state_d = ST_RESP_I;
      ST_ACC_D: state_d = ST_RESP_D;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, request latches and registered memory/response strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      i_valid_q     <= 1'b0;
      d_valid_q     <= 1'b0;
      i_err_q       <= 1'b0;
      d_err_q       <= 1'b0;
      m_i_en_q      <= 1'b0;
      m_d_en_q      <= 1'b0;
      m_d_write_n_q <= 1'b1;
      m_addr_q      <= '0;
      m_width_q     <= '0;
      m_wdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      m_i_en_q      <= (state_d == ST_ACC_I);
      m_d_en_q      <= (state_d == ST_ACC_D);
      m_d_write_n_q <= !((state_d == ST_ACC_D) && bus.d_we);
      i_valid_q     <= (state_d == ST_RESP_I);
      d_valid_q     <= (state_d == ST_RESP_D);
      if (any_gnt) begin
        m_addr_q <= gnt_addr;
        i_err_q  <= gnt_i && err;
        d_err_q  <= gnt_d && err;
      end
      if (gnt_d) begin
        m_width_q <= bus.d_width;
        m_wdata_q <= bus.d_wdata;
        we_q      <= bus.d_we;
      end
    end
  end

  assign i_rd = (i_valid_q && !i_err_q) ? bus.m_irdata : '0;
  assign d_rd = (d_valid_q && !d_err_q && !we_q)
                ? bus.m_drdata : '0;

  assign bus.i_gnt       = gnt_i;
  assign bus.i_valid     = i_valid_q;
  assign bus.i_rdata     = i_rd;
  assign bus.i_err       = i_valid_q && i_err_q;
  assign bus.d_gnt       = gnt_d;
  assign bus.d_valid     = d_valid_q;
  assign bus.d_rdata     = d_rd;
  assign bus.d_err       = d_valid_q && d_err_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_i_en      = m_i_en_q;
  assign bus.m_d_en      = m_d_en_q;
  assign bus.m_d_write_n = m_d_write_n_q;
  assign bus.m_width     = m_width_q;
  assign bus.m_wdata     = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table vectors, contested grants, mid-access reset.
// Big-endian byte memory model with registered read data.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   ld = 1'b1;
  int   cyc = 0;
  int   en_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [128];
  logic [6:0] wi;
  exp_t       sb[$];
  vec_t       vt[16];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.m_i_en || bus.m_d_en) en_cnt <= en_cnt + 1;
  end

  function automatic logic [7:0] init_b(input int k);
    case (k)
      0: return 8'h13;  1: return 8'h57;
      2: return 8'h9B;  3: return 8'hDF;
      4: return 8'h00;  5: return 8'h11;
      6: return 8'h22;  7: return 8'h33;
      64: return 8'hDE; 65: return 8'hAD;
      66: return 8'hC0; 67: return 8'hDE;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] mrd(input logic [31:0] a,
                                      input logic [1:0] w);
    logic [6:0] i;
    i = {a[17], a[5:0]};
    case (w)
      2'd0: return {24'h0, mem[i]};
      2'd1: return {16'h0, mem[i], mem[i+7'd1]};
      default: return {mem[i], mem[i+7'd1],
                       mem[i+7'd2], mem[i+7'd3]};
    endcase
  endfunction

  assign wi = {bus.m_addr[17], bus.m_addr[5:0]};

  always @(posedge clk) begin
    if (ld) begin
      for (int k = 0; k < 128; k++) mem[k] <= init_b(k);
      bus.m_irdata <= '0;
      bus.m_drdata <= '0;
    end else begin
      if (bus.m_i_en) bus.m_irdata <= mrd(bus.m_addr, 2'd2);
      if (bus.m_d_en) begin
        if (bus.m_d_write_n) begin
          bus.m_drdata <= mrd(bus.m_addr, bus.m_width);
        end else begin
          case (bus.m_width)
            2'd0: mem[wi] <= bus.m_wdata[7:0];
            2'd1: begin
              mem[wi]       <= bus.m_wdata[15:8];
              mem[wi+7'd1]  <= bus.m_wdata[7:0];
            end
            default: begin
              mem[wi]       <= bus.m_wdata[31:24];
              mem[wi+7'd1]  <= bus.m_wdata[23:16];
              mem[wi+7'd2]  <= bus.m_wdata[15:8];
              mem[wi+7'd3]  <= bus.m_wdata[7:0];
            end
          endcase
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop and compare on every response pulse
  always @(negedge clk) begin
    exp_t e;
    if (bus.i_valid || bus.d_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {bus.i_valid, bus.d_valid}, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_side", {bus.i_valid, bus.d_valid},
            e.is_d ? 2'b01 : 2'b10);
        chk("resp_cycle", cyc, e.cyc);
        chk("resp_err", e.is_d ? bus.d_err : bus.i_err, e.err);
        chk("resp_rdata", e.is_d ? bus.d_rdata : bus.i_rdata,
            e.rdata);
      end
    end
  end

  task automatic push(input bit is_d, input bit err,
                      input logic [31:0] rd, input int c);
    exp_t e;
    e.is_d  = is_d;
    e.err   = err;
    e.rdata = rd;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 6 && sb.size() != 0; k++) @(negedge clk);
    chk({nm, "_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_valid"}, {bus.i_valid, bus.d_valid}, 0);
    chk({nm, "_gnt"}, {bus.i_gnt, bus.d_gnt}, 0);
    chk({nm, "_err"}, {bus.i_err, bus.d_err}, 0);
    chk({nm, "_irdata"}, bus.i_rdata, 0);
    chk({nm, "_drdata"}, bus.d_rdata, 0);
    chk({nm, "_en"}, {bus.m_i_en, bus.m_d_en}, 0);
    chk({nm, "_wr_n"}, bus.m_d_write_n, 1);
    chk({nm, "_maddr"}, bus.m_addr, 0);
    chk({nm, "_mwidth"}, bus.m_width, 0);
    chk({nm, "_mwdata"}, bus.m_wdata, 0);
  endtask

  task automatic apply(input vec_t v, input string nm);
    bit got;
    int gc;
    int en0;
    @(posedge clk); #1;
    if (v.is_d) begin
      bus.d_req = 1; bus.d_addr = v.addr; bus.d_we = v.we;
      bus.d_width = v.width; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1; bus.i_addr = v.addr;
    end
    got = 0;
    gc  = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (v.is_d ? bus.d_gnt : bus.i_gnt) begin
        got = 1;
        gc  = cyc;
      end
    end
    chk({nm, "_gnt"}, got, 1);
    en0 = en_cnt;
    if (got) push(v.is_d, v.err, v.rdata, gc + (v.err ? 1 : 2));
    @(posedge clk); #1;
    bus.i_req = 0;
    bus.d_req = 0;
    @(negedge clk);
    if (v.err) begin
      chk({nm, "_no_en"}, {bus.m_i_en, bus.m_d_en}, 0);
    end else if (v.is_d) begin
      chk({nm, "_den"}, {bus.m_i_en, bus.m_d_en}, 2'b01);
      chk({nm, "_maddr"}, bus.m_addr, v.addr);
      chk({nm, "_wr_n"}, bus.m_d_write_n, !v.we);
      chk({nm, "_mwidth"}, bus.m_width, v.width);
      if (v.we) chk({nm, "_mwdata"}, bus.m_wdata, v.wdata);
    end else begin
      chk({nm, "_ien"}, {bus.m_i_en, bus.m_d_en}, 2'b10);
      chk({nm, "_maddr"}, bus.m_addr, v.addr);
    end
    drain(nm);
    if (v.err) chk({nm, "_en_cnt"}, en_cnt, en0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    string exp_pat;
    string got_pat;
    int    t0;
    int    gc;
    int    prev;
    int    n;
    bit    got;

    //       is_d we width  addr          wdata         err rdata
    vt[0]  = '{0, 0, W_WORD, 32'h0001_0000, 32'h0, 0, 32'h1357_9BDF};
    vt[1]  = '{0, 0, W_WORD, 32'h0001_0004, 32'h0, 0, 32'h0011_2233};
    vt[2]  = '{1, 0, W_WORD, 32'h0002_0000, 32'h0, 0, 32'hDEAD_C0DE};
    vt[3]  = '{1, 0, W_BYTE, 32'h0002_0001, 32'h0, 0, 32'h0000_00AD};
    vt[4]  = '{1, 0, W_HALF, 32'h0002_0002, 32'h0, 0, 32'h0000_C0DE};
    vt[5]  = '{1, 1, W_HALF, 32'h0002_0002, 32'hBEEF, 0, 32'h0};
    vt[6]  = '{1, 0, W_HALF, 32'h0002_0002, 32'h0, 0, 32'h0000_BEEF};
    vt[7]  = '{1, 1, W_BYTE, 32'h0002_0001, 32'h5A, 0, 32'h0};
    vt[8]  = '{1, 0, W_WORD, 32'h0002_0000, 32'h0, 0, 32'hDE5A_BEEF};
    vt[9]  = '{1, 0, W_WORD, 32'h0002_0001, 32'h0, 1, 32'h0};
    vt[10] = '{0, 0, W_WORD, 32'h0001_0002, 32'h0, 1, 32'h0};
    vt[11] = '{1, 0, 2'd3,   32'h0002_0000, 32'h0, 1, 32'h0};
    vt[12] = '{1, 0, W_HALF, 32'h0002_0003, 32'h0, 1, 32'h0};
    vt[13] = '{1, 0, W_BYTE, 32'h0002_0003, 32'h0, 0, 32'h0000_00EF};
    vt[14] = '{1, 1, W_WORD, 32'h0002_0001, 32'hFFFF_FFFF, 1, 32'h0};
    vt[15] = '{1, 0, W_WORD, 32'h0002_0000, 32'h0, 0, 32'hDE5A_BEEF};

    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_addr = '0; bus.d_we = 0;
    bus.d_width = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("por");
    @(posedge clk); #1;
    reset = 0;
    ld    = 0;

    // Contested: data first, fetch granted 3 cycles later
    @(posedge clk); #1;
    bus.i_req = 1; bus.i_addr = 32'h0001_0000;
    bus.d_req = 1; bus.d_addr = 32'h0002_0000;
    bus.d_we = 0; bus.d_width = W_WORD;
    @(negedge clk);
    chk("both_gnt", {bus.i_gnt, bus.d_gnt}, 2'b01);
    t0 = cyc;
    push(1, 0, 32'hDEAD_C0DE, t0 + 2);
    @(posedge clk); #1;
    bus.d_req = 0;
    got = 0;
    gc  = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.i_gnt) begin
        got = 1;
        gc  = cyc;
      end
    end
    chk("both_igap", gc - t0, 3);
    if (got) push(0, 0, 32'h1357_9BDF, gc + 2);
    @(posedge clk); #1;
    bus.i_req = 0;
    drain("both");

    // Both held across six grants
`ifdef MEM_ARB_RR_EN
    exp_pat = "DIDIDI";
`else
    exp_pat = "DDDDDD";
`endif
    got_pat = "";
    @(posedge clk); #1;
    bus.i_req = 1;
    bus.d_req = 1;
    n    = 0;
    prev = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      @(negedge clk);
      if (bus.i_gnt || bus.d_gnt) begin
        if (n > 0) chk($sformatf("hold_gap%0d", n), cyc - prev, 3);
        prev = cyc;
        got_pat = {got_pat, bus.d_gnt ? "D" : "I"};
        chk($sformatf("hold_g%0d", n), bus.d_gnt,
            exp_pat[n] == "D");
        if (bus.d_gnt) push(1, 0, 32'hDEAD_C0DE, cyc + 2);
        else push(0, 0, 32'h1357_9BDF, cyc + 2);
        n++;
      end
    end
    chk("hold_count", n, 6);
    @(posedge clk); #1;
    bus.i_req = 0;
    bus.d_req = 0;
    drain("hold");

    for (int i = 0; i < 16; i++) apply(vt[i], $sformatf("v%0d", i));

    // Reset during ACC_D of a load drops it
    @(posedge clk); #1;
    bus.d_req = 1; bus.d_addr = 32'h0002_0000;
    bus.d_we = 0; bus.d_width = W_WORD;
    @(negedge clk);
    chk("rst_gnt", bus.d_gnt, 1);
    @(posedge clk); #1;
    bus.d_req = 0;
    reset = 1;
    @(negedge clk);
    chk("rst_acc_den", bus.m_d_en, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_rst("mid");
    @(posedge clk); #1;
    reset = 0;
    repeat (4) @(negedge clk);
    apply(vt[15], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
